// File: rtl/pkt_chan_arbiter.sv
// Round-robin arbiter that hands one packet channel to a single requester for a
// whole packet (head..tail), enforcing a maximum packet length.
module pkt_chan_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DW      = 8,
   parameter int MAX_LEN = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    in_valid,
   input  logic [NUM_REQ-1:0]    in_head,
   input  logic [NUM_REQ-1:0]    in_tail,
   input  logic [NUM_REQ*DW-1:0] in_data,
   output logic [NUM_REQ-1:0]    grant,
   output logic                  out_valid,
   output logic                  out_head,
   output logic                  out_tail,
   output logic [DW-1:0]         out_data,
   output logic [1:0]            arb_state,
   output logic                  proto_err,
   output logic                  len_err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_GRANT = 2'b01,
      ARB_BUSY  = 2'b10,
      ARB_DRAIN = 2'b11
   } arb_state_e;

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                out_head_q, out_head_d;
   logic                out_tail_q, out_tail_d;
   logic [DW-1:0]       out_data_q, out_data_d;
   logic                proto_err_q, proto_err_d;
   logic                len_err_q, len_err_d;

   logic                g_valid, g_head, g_tail, g_req;
   logic [DW-1:0]       g_data;
   logic [NUM_REQ-1:0]  hi_mask, req_hi, pick_vec, win_oh;
   logic [IW-1:0]       win_idx, ptr_nxt;
   logic                at_limit;

   // Only the granted requester's beat is visible to the FSM.
   always_comb begin
      g_valid = |(in_valid & grant_q);
      g_head  = |(in_head & grant_q);
      g_tail  = |(in_tail & grant_q);
      g_req   = |(req & grant_q);
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) g_data = in_data[i*DW +: DW];
      end
   end

   // Requests at or above the pointer win first; otherwise wrap to the lowest index.
   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (i >= int'(ptr_q));
      end
      req_hi   = req & hi_mask;
      pick_vec = (|req_hi) ? req_hi : req;
      win_idx  = '0;
      win_oh   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            win_idx    = IW'(i);
            win_oh     = '0;
            win_oh[i]  = 1'b1;
         end
      end
      ptr_nxt = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
   end

   assign at_limit = (cnt_q == CW'(MAX_LEN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         grant_q     <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_head_q  <= 1'b0;
         out_tail_q  <= 1'b0;
         out_data_q  <= '0;
         proto_err_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_head_q  <= out_head_d;
         out_tail_q  <= out_tail_d;
         out_data_q  <= out_data_d;
         proto_err_q <= proto_err_d;
         len_err_q   <= len_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            cnt_d = '0;
            if (|req) begin
               state_d = ARB_GRANT;
               grant_d = win_oh;
               ptr_d   = ptr_nxt;
            end
         end
         ARB_GRANT: begin
            if (g_valid && g_head) begin
               if (g_tail) begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
               end else begin
                  state_d = ARB_BUSY;
                  cnt_d   = CW'(1);
               end
            end else if (!g_valid && !g_req) begin
               state_d = ARB_IDLE;
               grant_d = '0;
            end
         end
         ARB_BUSY: begin
            // req is ignored here: the grant is held until tail or abort.
            if (g_valid) begin
               cnt_d = cnt_q + CW'(1);
               if (g_tail) begin
                  state_d = ARB_IDLE;
                  grant_d = '0;
               end else if (at_limit) begin
                  state_d = ARB_DRAIN;
               end
            end
         end
         ARB_DRAIN: begin
            if (g_valid && g_tail) begin
               state_d = ARB_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      out_valid_d = 1'b0;
      out_head_d  = 1'b0;
      out_tail_d  = 1'b0;
      out_data_d  = '0;
      proto_err_d = 1'b0;
      len_err_d   = 1'b0;
      case (state_q)
         ARB_GRANT: begin
            if (g_valid) begin
               if (g_head) begin
                  out_valid_d = 1'b1;
                  out_head_d  = 1'b1;
                  out_tail_d  = g_tail;
                  out_data_d  = g_data;
               end else begin
                  proto_err_d = 1'b1;
               end
            end
         end
         ARB_BUSY: begin
            // Mid-packet heads are demoted; an over-long packet is closed with a forced tail.
            if (g_valid) begin
               out_valid_d = 1'b1;
               out_tail_d  = g_tail | at_limit;
               out_data_d  = g_data;
               proto_err_d = g_head & ~g_tail;
               len_err_d   = at_limit & ~g_tail;
            end
         end
         default: begin
         end
      endcase
   end

   assign grant     = grant_q;
   assign out_valid = out_valid_q;
   assign out_head  = out_head_q;
   assign out_tail  = out_tail_q;
   assign out_data  = out_data_q;
   assign arb_state = state_q;
   assign proto_err = proto_err_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_pkt_chan_arbiter.sv
// Bench for pkt_chan_arbiter: directed packet scenarios followed by random traffic,
// all outputs compared each cycle against a packet-level reference model.
module tb_pkt_chan_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DW      = 8;
   localparam int MAX_LEN = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    in_valid;
   logic [NUM_REQ-1:0]    in_head;
   logic [NUM_REQ-1:0]    in_tail;
   logic [NUM_REQ*DW-1:0] in_data;
   logic [NUM_REQ-1:0]    grant;
   logic                  out_valid;
   logic                  out_head;
   logic                  out_tail;
   logic [DW-1:0]         out_data;
   logic [1:0]            arb_state;
   logic                  proto_err;
   logic                  len_err;

   pkt_chan_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .MAX_LEN(MAX_LEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in_valid  (in_valid),
      .in_head   (in_head),
      .in_tail   (in_tail),
      .in_data   (in_data),
      .grant     (grant),
      .out_valid (out_valid),
      .out_head  (out_head),
      .out_tail  (out_tail),
      .out_data  (out_data),
      .arb_state (arb_state),
      .proto_err (proto_err),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the channel, whether a packet is open or being drained.
   int                 m_owner;
   int                 m_ptr;
   int                 m_beats;
   bit                 m_open;
   bit                 m_drain;
   logic [NUM_REQ-1:0] exp_grant;
   logic               exp_valid, exp_head, exp_tail, exp_perr, exp_lerr;
   logic [DW-1:0]      exp_data;
   logic [1:0]         exp_state;
   logic [NUM_REQ-1:0] exp_q[$];

   bit pend [NUM_REQ];
   int plen [NUM_REQ];
   int sent [NUM_REQ];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_close();
      m_owner = -1;
      m_open  = 1'b0;
      m_drain = 1'b0;
      m_beats = 0;
   endtask

   task automatic model_derive();
      exp_grant = '0;
      for (int i = 0; i < NUM_REQ; i++) if (i == m_owner) exp_grant[i] = 1'b1;
      if (m_owner < 0)  exp_state = 2'b00;
      else if (m_drain) exp_state = 2'b11;
      else if (m_open)  exp_state = 2'b10;
      else              exp_state = 2'b01;
   endtask

   task automatic model_reset();
      model_close();
      m_ptr     = 0;
      exp_valid = 1'b0;
      exp_head  = 1'b0;
      exp_tail  = 1'b0;
      exp_data  = '0;
      exp_perr  = 1'b0;
      exp_lerr  = 1'b0;
      model_derive();
   endtask

   // Predicts the outputs produced by the coming clock edge from the current inputs.
   task automatic model_edge();
      bit            v, h, t, r;
      logic [DW-1:0] d;
      exp_valid = 1'b0;
      exp_head  = 1'b0;
      exp_tail  = 1'b0;
      exp_data  = '0;
      exp_perr  = 1'b0;
      exp_lerr  = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (m_ptr + k) % NUM_REQ;
            if (m_owner < 0 && req[c]) begin
               m_owner = c;
               m_ptr   = (c + 1) % NUM_REQ;
            end
         end
      end else begin
         v = 1'b0; h = 1'b0; t = 1'b0; r = 1'b0; d = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i == m_owner) begin
               v = in_valid[i]; h = in_head[i]; t = in_tail[i]; r = req[i];
               d = in_data[i*DW +: DW];
            end
         end
         if (m_drain) begin
            if (v && t) model_close();
         end else if (m_open) begin
            if (v) begin
               m_beats++;
               exp_valid = 1'b1;
               exp_data  = d;
               exp_tail  = t;
               exp_perr  = h && !t;
               if (t) model_close();
               else if (m_beats == MAX_LEN) begin
                  exp_tail = 1'b1;
                  exp_lerr = 1'b1;
                  m_open   = 1'b0;
                  m_drain  = 1'b1;
               end
            end
         end else begin
            if (v && h) begin
               exp_valid = 1'b1;
               exp_head  = 1'b1;
               exp_tail  = t;
               exp_data  = d;
               if (t) model_close();
               else begin
                  m_open  = 1'b1;
                  m_beats = 1;
               end
            end else if (v) exp_perr = 1'b1;
            else if (!r) model_close();
         end
      end
      model_derive();
   endtask

   task automatic check_outputs();
      check("grant", grant, exp_grant);
      check("out_valid", out_valid, exp_valid);
      check("out_head", out_head, exp_head);
      check("out_tail", out_tail, exp_tail);
      check("out_data", out_data, exp_data);
      check("arb_state", arb_state, exp_state);
      check("proto_err", proto_err, exp_perr);
      check("len_err", len_err, exp_lerr);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clear_beats();
      in_valid = '0;
      in_head  = '0;
      in_tail  = '0;
      in_data  = '0;
   endtask

   task automatic clear_in();
      req = '0;
      clear_beats();
   endtask

   task automatic beat(input int r, input bit h, input bit t, input logic [DW-1:0] d);
      clear_beats();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i == r) begin
            in_valid[i]          = 1'b1;
            in_head[i]           = h;
            in_tail[i]           = t;
            in_data[i*DW +: DW]  = d;
         end
      end
   endtask

   initial begin
      int o;
      // Clock/reset: outputs must be clear before any clock edge.
      reset = 1'b1;
      clear_in();
      model_reset();
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // All four requesting: 2-beat packets granted 0,1,2,3,0 with one idle cycle between.
      exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      req = '1;
      for (int p = 0; p < 5; p++) begin
         step();
         check("rr_order", grant, exp_q.pop_front());
         o = (m_owner < 0) ? 0 : m_owner;
         beat(o, 1'b1, 1'b0, 8'(8'h10 + p));
         step();
         beat(o, 1'b0, 1'b1, 8'(8'h20 + p));
         step();
         check("rr_gap_state", arb_state, 2'b00);
         clear_beats();
      end
      clear_in();
      step();

      // Requester 0 alone: head, data, tail.
      req = 4'b0001;
      step();
      check("t1_grant", grant, 4'b0001);
      check("t1_state_grant", arb_state, 2'b01);
      beat(0, 1'b1, 1'b0, 8'hA1);
      step();
      check("t1_state_busy", arb_state, 2'b10);
      beat(0, 1'b0, 1'b0, 8'hA2);
      step();
      beat(0, 1'b0, 1'b1, 8'hA3);
      step();
      check("t1_grant_released", grant, 4'b0000);
      check("t1_state_idle", arb_state, 2'b00);
      clear_in();
      step();

      // Requester 2: single-beat packet.
      req = 4'b0100;
      step();
      beat(2, 1'b1, 1'b1, 8'h5C);
      step();
      check("single_head_tail", {out_head, out_tail}, 2'b11);
      check("single_idle", arb_state, 2'b00);
      clear_in();
      step();

      // Requester 1: beat without head while in GRANT is dropped and flagged.
      req = 4'b0010;
      step();
      beat(1, 1'b0, 1'b0, 8'h77);
      step();
      check("noh_proto_err", proto_err, 1'b1);
      check("noh_out_valid", out_valid, 1'b0);
      check("noh_state", arb_state, 2'b01);
      beat(1, 1'b1, 1'b1, 8'h78);
      step();
      clear_in();
      step();

      // Requester 1: 20-beat packet, aborted at MAX_LEN then drained until its tail.
      req = 4'b0010;
      step();
      for (int b = 1; b <= 20; b++) begin
         beat(1, b == 1, b == 20, 8'(b));
         step();
         if (b == MAX_LEN) begin
            check("len_forced_tail", {out_valid, out_tail}, 2'b11);
            check("len_err_pulse", len_err, 1'b1);
         end
         if (b > MAX_LEN && b < 20) check("len_drop", out_valid, 1'b0);
      end
      check("len_idle", arb_state, 2'b00);
      clear_in();
      step();

      // Reset in the middle of a packet clears outputs without a clock edge.
      req = 4'b0001;
      step();
      beat(0, 1'b1, 1'b0, 8'hC1);
      step();
      beat(0, 1'b0, 1'b0, 8'hC2);
      step();
      check("pre_reset_busy", arb_state, 2'b10);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      clear_in();
      @(negedge clk);
      reset = 1'b0;
      req = '1;
      step();
      check("post_reset_winner", grant, 4'b0001);
      clear_in();
      step();
      step();

      // Random traffic with occasional protocol errors, abandoned requests and long packets.
      for (int i = 0; i < NUM_REQ; i++) begin
         pend[i] = 1'b0;
         plen[i] = 0;
         sent[i] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && m_owner != i && $urandom_range(0, 5) == 0) begin
               pend[i] = 1'b1;
               plen[i] = $urandom_range(1, 20);
               sent[i] = 0;
            end
            req[i]              = pend[i];
            in_valid[i]         = 1'($urandom_range(0, 1));
            in_head[i]          = 1'($urandom_range(0, 1));
            in_tail[i]          = 1'($urandom_range(0, 1));
            in_data[i*DW +: DW] = DW'($urandom);
            if (m_owner == i) begin
               if (!pend[i]) begin
                  in_valid[i] = 1'b0;
               end else if (sent[i] == 0 && !m_open && $urandom_range(0, 15) == 0) begin
                  pend[i]     = 1'b0;
                  req[i]      = 1'b0;
                  in_valid[i] = 1'b0;
               end else begin
                  in_valid[i] = ($urandom_range(0, 3) != 0);
                  in_head[i]  = (sent[i] == 0) ^ ($urandom_range(0, 15) == 0);
                  in_tail[i]  = (sent[i] == plen[i] - 1);
                  if (in_valid[i]) begin
                     sent[i]++;
                     if (in_tail[i]) pend[i] = 1'b0;
                  end
               end
            end
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pkt_chan_arbiter.md
Name: pkt_chan_arbiter

Overview:
- Round-robin arbiter sharing one packet channel (valid/head/tail/data) among NUM_REQ requesters.
- Grant is held for a whole packet, head beat through tail beat, so packets never interleave.
- Sits in front of the channel state machine (IDLE/HEAD/DATA/TAIL) and drives its valid/head/tail inputs.
- Enforces a maximum packet length and flags protocol violations.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- MAX_LEN, 16, maximum beats per packet including head and tail (>=2).

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request, level, held until tail is accepted.
- in_valid  input  NUM_REQ  per-requester beat valid.
- in_head  input  NUM_REQ  per-requester head flag.
- in_tail  input  NUM_REQ  per-requester tail flag.
- in_data  input  NUM_REQ*DW  flattened data; requester i uses bits [i*DW +: DW].
- grant  output  NUM_REQ  registered one-hot grant.
- out_valid  output  1  registered channel valid.
- out_head  output  1  registered channel head.
- out_tail  output  1  registered channel tail.
- out_data  output  DW  registered channel data.
- arb_state  output  2  current state, exported for FSM coverage.
- proto_err  output  1  one-cycle pulse on protocol violation.
- len_err  output  1  one-cycle pulse on packet-length abort.

Behaviour:
- Reset:
  - grant = 0, all out_* = 0, proto_err = len_err = 0.
  - arb_state = ARB_IDLE.
  - RR pointer = requester 0 has highest priority.
  - Beat counter = 0.
- States: ARB_IDLE 2'b00, ARB_GRANT 2'b01, ARB_BUSY 2'b10, ARB_DRAIN 2'b11.
- ARB_IDLE:
  - If any req bit is set, select the first set bit searching upward (with wrap) from the pointer.
  - Next cycle: grant = that one-hot, state = ARB_GRANT, pointer = winner+1 mod NUM_REQ.
  - No req: stay in ARB_IDLE.
- ARB_GRANT (granted requester g only; other inputs are ignored):
  - valid & head & tail: single-beat packet forwarded -> ARB_IDLE.
  - valid & head & !tail: forwarded, counter = 1 -> ARB_BUSY.
  - valid & !head: beat dropped, proto_err pulse, stay in ARB_GRANT.
  - req[g] low with no valid: grant released -> ARB_IDLE.
- ARB_BUSY:
  - Every valid beat is forwarded and the counter increments.
  - valid & tail -> ARB_IDLE.
  - valid & head (without tail): forwarded with out_head forced to 0, proto_err pulse.
  - Counter reaches MAX_LEN-1 and the current valid beat is not a tail:
    - That beat is forwarded with out_tail forced to 1, closing the packet downstream.
    - len_err pulse, state -> ARB_DRAIN.
  - req[g] deasserts before tail: ignored; grant is held until tail or abort.
- ARB_DRAIN:
  - Inputs from g are consumed, out_valid = 0.
  - On valid & tail from g -> ARB_IDLE.
- Grant timing:
  - grant deasserts in the cycle after the tail beat is sampled.
  - Earliest next grant is one cycle later, from ARB_IDLE. Minimum gap between packets is 1 idle cycle.
- Latency: an input beat sampled at edge N appears on out_* after edge N (1 cycle).
- out_valid = 0 on every cycle with no forwarded beat; out_head/out_tail/out_data are 0 when out_valid = 0.
- Simultaneous requests: strict round-robin, so a requester that just completed a packet has lowest priority next.
- Reset mid-packet: immediate return to reset values; no tail is emitted and the downstream FSM relies on the same reset.

Test Plan:
- Single requester 0 sends head, data, tail beats -> grant = 4'b0001 one cycle after req; out_* mirrors the beats one cycle late; grant = 0 after tail; arb_state walks 00, 01, 10, 00.
- req = 4'b1111 held, each requester sends 2-beat packets -> grant order 0, 1, 2, 3, 0; no interleaving; 1-cycle gap between packets.
- Requester 2 sends a single beat with head = tail = 1 -> one out beat with out_head = out_tail = 1; back to ARB_IDLE.
- Granted requester sends valid with head = 0 in ARB_GRANT -> proto_err pulse, out_valid stays 0, state stays 01.
- MAX_LEN = 16, requester 1 sends 20 beats without tail -> 16th out beat has out_tail = 1; len_err pulses; beats 17-19 dropped; tail at beat 20 -> ARB_IDLE.
- Assert reset during ARB_BUSY -> outputs clear asynchronously with no clock edge; after release, requester 0 wins the first arbitration.
